// File: rtl/mmio_bridge_pkg.sv
// rtl/mmio_bridge_pkg.sv - shared command layout, read tag and FSM types for the MMIO bridge
package mmio_bridge_pkg;

    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = 64;
    localparam int WR_BIT   = 82;
    localparam int SZ_BIT   = 83;
    localparam int CMD_W    = 84;
    localparam int RSP_W    = 64;

    // Remembers how to format a read beat when it comes back.
    typedef struct packed {
        logic size64;
        logic hi;
    } rd_tag_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

endpackage

// File: rtl/mmio_bridge_fifo.sv
// rtl/mmio_bridge_fifo.sv - show-ahead synchronous FIFO with occupancy count
module mmio_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_avst_to_avmm_bridge.sv
// rtl/mmio_avst_to_avmm_bridge.sv - MMIO command/response stream to Avalon-MM master bridge
module mmio_avst_to_avmm_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int MAX_RD_OUTST = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [CMD_W-1:0]  avst_mmio_cmd_data,
    input  logic              avst_mmio_cmd_valid,
    output logic              avst_mmio_cmd_ready,
    output logic [RSP_W-1:0]  avst_mmio_rsp_data,
    output logic              avst_mmio_rsp_valid,
    input  logic              avst_mmio_rsp_ready,
    output logic [ADDR_W-1:0] avmm_address,
    output logic              avmm_read,
    output logic              avmm_write,
    output logic [63:0]       avmm_writedata,
    output logic [7:0]        avmm_byteenable,
    input  logic              avmm_waitrequest,
    input  logic [63:0]       avmm_readdata,
    input  logic              avmm_readdatavalid
);

    localparam int CW = $clog2(MAX_RD_OUTST+1);

    state_t            state;
    state_t            state_nxt;
    logic              q_write;
    logic              q_size64;
    logic              q_hi;
    logic [ADDR_W-4:0] q_addr;
    logic [63:0]       q_data;
    logic [CW-1:0]     outst;
    logic              post_reset;

    logic              accept;
    logic              rd_issue;
    logic              rd_return;
    logic [CW:0]       credit_used;
    logic              credit_ok;

    rd_tag_t           tag_in;
    rd_tag_t           tag_head;
    logic              tag_empty;
    logic              tag_full;
    logic [CW-1:0]     tag_count;

    logic [RSP_W-1:0]  rsp_push_data;
    logic [RSP_W-1:0]  rsp_head;
    logic              rsp_empty;
    logic              rsp_full;
    logic [CW-1:0]     rsp_count;
    logic              rsp_pop;

    logic              unused;

    // Reads already in flight plus beats parked in the rsp FIFO are the credits in use;
    // a new read is admitted only while a free slot remains for its response.
    assign credit_used = {1'b0, outst} + {1'b0, rsp_count};
    assign credit_ok   = credit_used < (CW+1)'(MAX_RD_OUTST);

    assign avst_mmio_cmd_ready = !reset_reset && (state == IDLE)
                               && (avst_mmio_cmd_data[WR_BIT] || credit_ok);
    assign accept              = avst_mmio_cmd_valid && avst_mmio_cmd_ready;

    // Beats arriving with nothing outstanding are dropped rather than corrupting state.
    assign rd_return = avmm_readdatavalid && (outst != '0);

    // Next state and Avalon-MM master outputs; everything idles to zero under reset.
    always_comb begin
        state_nxt       = state;
        avmm_read       = 1'b0;
        avmm_write      = 1'b0;
        avmm_address    = '0;
        avmm_writedata  = '0;
        avmm_byteenable = '0;
        rd_issue        = 1'b0;
        if (!reset_reset) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    avmm_read       = !q_write;
                    avmm_write      = q_write;
                    avmm_address    = {q_addr, 3'b000};
                    avmm_byteenable = q_size64 ? 8'hFF : (q_hi ? 8'hF0 : 8'h0F);
                    avmm_writedata  = q_size64 ? q_data : {q_data[31:0], q_data[31:0]};
                    if (!avmm_waitrequest) begin
                        state_nxt = IDLE;
                        rd_issue  = !q_write;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the accepted command for the ISSUE phase.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            q_write  <= 1'b0;
            q_size64 <= 1'b0;
            q_hi     <= 1'b0;
            q_addr   <= '0;
            q_data   <= '0;
        end else if (accept) begin
            q_write  <= avst_mmio_cmd_data[WR_BIT];
            q_size64 <= avst_mmio_cmd_data[SZ_BIT];
            q_hi     <= avst_mmio_cmd_data[ADDR_LSB+2];
            q_addr   <= avst_mmio_cmd_data[ADDR_LSB+3 +: ADDR_W-3];
            q_data   <= avst_mmio_cmd_data[DATA_LSB +: 64];
        end
    end

    // Outstanding read counter; simultaneous issue and return cancel out.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            outst <= '0;
        end else if (rd_issue && !rd_return) begin
            outst <= outst + CW'(1);
        end else if (!rd_issue && rd_return) begin
            outst <= outst - CW'(1);
        end
    end

    // Reads abandoned by a reset may still return; tolerate them until a new read is issued.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            post_reset <= 1'b1;
        end else if (rd_issue) begin
            post_reset <= 1'b0;
        end
    end

    // A beat with no read outstanding means the fabric broke the protocol.
    a_no_orphan_beat : assert property (@(posedge clk_clk) disable iff (reset_reset)
        avmm_readdatavalid |-> (outst != '0 || post_reset));

    assign tag_in.size64 = q_size64;
    assign tag_in.hi     = q_hi;

    mmio_bridge_fifo #(
        .WIDTH ($bits(rd_tag_t)),
        .DEPTH (MAX_RD_OUTST)
    ) u_tag_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (rd_issue),
        .push_data (tag_in),
        .pop       (rd_return),
        .head      (tag_head),
        .empty     (tag_empty),
        .full      (tag_full),
        .count     (tag_count)
    );

    assign rsp_push_data = tag_head.size64 ? avmm_readdata
                         : {32'h0, tag_head.hi ? avmm_readdata[63:32] : avmm_readdata[31:0]};

    assign avst_mmio_rsp_valid = !rsp_empty && !reset_reset;
    assign avst_mmio_rsp_data  = avst_mmio_rsp_valid ? rsp_head : '0;
    assign rsp_pop             = avst_mmio_rsp_valid && avst_mmio_rsp_ready;

    mmio_bridge_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (MAX_RD_OUTST)
    ) u_rsp_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (rd_return),
        .push_data (rsp_push_data),
        .pop       (rsp_pop),
        .head      (rsp_head),
        .empty     (rsp_empty),
        .full      (rsp_full),
        .count     (rsp_count)
    );

    // Address bits [1:0] are meaningless on this fabric; FIFO flags are covered by the credit rule.
    assign unused = &{1'b0, avst_mmio_cmd_data[ADDR_LSB +: 2], tag_empty, tag_full, tag_count, rsp_full};

endmodule
